// File: rtl/jpeg_bitbuffer.sv
// Entropy-coded-data bit buffer: bytes in, 32-bit MSB-aligned window out, variable-width pop.
// Define JPEG_BITBUFFER_UNSTUFF_EN to drop the 0x00 that follows each 0xFF in the payload.
module jpeg_bitbuffer (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        img_start_i,
  input  logic        img_end_i,
  input  logic        inport_valid_i,
  input  logic [7:0]  inport_data_i,
  input  logic        inport_last_i,
  output logic        inport_accept_o,
  input  logic [5:0]  outport_pop_i,
  output logic        outport_valid_o,
  output logic [31:0] outport_data_o,
  output logic        outport_last_o
);

  logic [63:0] buf_q, buf_d;
  logic [6:0]  count_q, count_d;
  logic        last_q, last_d;

  logic        flush;
  logic        accept;
  logic        window_valid;
  logic        take;
  logic        store;
  logic        drop;
  logic [5:0]  pop_eff;
  logic [6:0]  count_after_pop;
  logic [63:0] buf_shifted;
  logic [63:0] byte_placed;

  assign flush        = img_start_i | img_end_i;
  assign accept       = (count_q <= 7'd56) && !rst_i && !flush;
  assign window_valid = (count_q >= 7'd32) || (last_q && (count_q != 7'd0));
  assign take         = inport_valid_i && accept;
  assign store        = take && !drop;

`ifdef JPEG_BITBUFFER_UNSTUFF_EN
  logic ff_q, ff_d;

  // A 0x00 right after a stored 0xFF is stuffing, not payload.
  assign drop = ff_q && (inport_data_i == 8'h00);

  always_comb begin
    ff_d = ff_q;
    if (flush) begin
      ff_d = 1'b0;
    end else if (take) begin
      ff_d = (inport_data_i == 8'hFF);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ff_q <= 1'b0;
    end else begin
      ff_q <= ff_d;
    end
  end
`else
  assign drop = 1'b0;
`endif

  // Pops only count while the window is valid, and never beyond what is held.
  always_comb begin
    pop_eff = 6'd0;
    if (window_valid) begin
      if ({1'b0, outport_pop_i} > count_q) begin
        pop_eff = count_q[5:0];
      end else begin
        pop_eff = outport_pop_i;
      end
    end
  end

  always_comb begin
    count_after_pop = count_q - {1'b0, pop_eff};
    buf_shifted     = buf_q << pop_eff;
    byte_placed     = {inport_data_i, 56'd0} >> count_after_pop;

    buf_d   = buf_q;
    count_d = count_q;
    last_d  = last_q;

    if (flush) begin
      buf_d   = 64'd0;
      count_d = 7'd0;
      last_d  = 1'b0;
    end else begin
      buf_d   = store ? (buf_shifted | byte_placed) : buf_shifted;
      count_d = count_after_pop + (store ? 7'd8 : 7'd0);
      if (take && inport_last_i) begin
        last_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q   <= 64'd0;
      count_q <= 7'd0;
      last_q  <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      count_q <= count_d;
      last_q  <= last_d;
    end
  end

  assign inport_accept_o = accept;
  assign outport_valid_o = window_valid;
  assign outport_data_o  = buf_q[63:32];
  assign outport_last_o  = last_q && (count_q <= 7'd32);

endmodule

// File: tb/tb_jpeg_bitbuffer.sv
// Bench for jpeg_bitbuffer: bit-queue reference model feeding an expected-result scoreboard.
// Honours JPEG_BITBUFFER_UNSTUFF_EN the same way the design does.
module tb_jpeg_bitbuffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        img_start;
  logic        img_end;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        in_accept;
  logic [5:0]  pop;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_last;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  jpeg_bitbuffer dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .img_start_i     (img_start),
    .img_end_i       (img_end),
    .inport_valid_i  (in_valid),
    .inport_data_i   (in_data),
    .inport_last_i   (in_last),
    .inport_accept_o (in_accept),
    .outport_pop_i   (pop),
    .outport_valid_o (out_valid),
    .outport_data_o  (out_data),
    .outport_last_o  (out_last)
  );

  typedef struct {
    logic [31:0] data;
    logic        valid;
    logic        last;
    logic [6:0]  count;
  } exp_t;

  exp_t sb_q[$];
  bit   mq[$];
  bit   m_last;
  bit   m_ff;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] want);
    n_total++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] model_window();
    logic [31:0] w;
    w = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < mq.size()) w[31-i] = mq[i];
    end
    return w;
  endfunction

  // Drive one cycle, predict the post-edge state, then compare after the edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic l, input int p,
                       input logic st, input logic en);
    int   sz;
    int   pe;
    bit   m_valid;
    bit   m_accept;
    bit   drop;
    exp_t e;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    pop       = p[5:0];
    img_start = st;
    img_end   = en;
    #1;
    sz       = mq.size();
    m_valid  = (sz >= 32) || (m_last && sz != 0);
    m_accept = (sz <= 56) && !rst && !st && !en;
    check_eq("accept", {63'd0, in_accept}, {63'd0, m_accept});
    if (rst || st || en) begin
      mq.delete();
      m_last = 0;
      m_ff   = 0;
    end else begin
      pe = m_valid ? ((p < sz) ? p : sz) : 0;
      repeat (pe) void'(mq.pop_front());
      if (v && m_accept) begin
        drop = 0;
`ifdef JPEG_BITBUFFER_UNSTUFF_EN
        drop = m_ff && (d == 8'h00);
        m_ff = (d == 8'hFF);
`endif
        if (!drop) begin
          for (int b = 7; b >= 0; b--) mq.push_back(d[b]);
        end
        if (l) m_last = 1;
      end
    end
    e.data  = model_window();
    e.valid = (mq.size() >= 32) || (m_last && mq.size() != 0);
    e.last  = m_last && (mq.size() <= 32);
    e.count = 7'(mq.size());
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("data",  {32'd0, out_data},       {32'd0, e.data});
    check_eq("valid", {63'd0, out_valid},      {63'd0, e.valid});
    check_eq("last",  {63'd0, out_last},       {63'd0, e.last});
    check_eq("count", {57'd0, dut.count_q},    {57'd0, e.count});
  endtask

  task automatic idle_flush();
    cycle(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b1);
  endtask

  initial begin
    rst = 1'b1;
    m_last = 0;
    m_ff = 0;
    cycle(1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h55, 1'b0, 0, 1'b0, 1'b0);
    rst = 1'b0;
    in_valid = 1'b0;
    #1;
    check_eq("reset_accept", {63'd0, in_accept}, 64'd1);
    check_eq("reset_valid",  {63'd0, out_valid}, 64'd0);
    check_eq("reset_data",   {32'd0, out_data},  64'd0);
    check_eq("reset_last",   {63'd0, out_last},  64'd0);

    // Fill from empty
    cycle(1'b1, 8'h12, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h34, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h56, 1'b0, 0, 1'b0, 1'b0);
    check_eq("fill_valid_3", {63'd0, out_valid}, 64'd0);
    cycle(1'b1, 8'h78, 1'b0, 0, 1'b0, 1'b0);
    check_eq("fill_valid_4", {63'd0, out_valid}, 64'd1);
    check_eq("fill_data",    {32'd0, out_data},  64'h12345678);
    check_eq("fill_last",    {63'd0, out_last},  64'd0);

    // Push and pop together
    cycle(1'b1, 8'h9A, 1'b0, 4, 1'b0, 1'b0);
    check_eq("pushpop_data",  {32'd0, out_data},    64'h23456789);
    check_eq("pushpop_count", {57'd0, dut.count_q}, 64'd36);
    idle_flush();

    // Stuffing
    cycle(1'b1, 8'hFF, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h00, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hAB, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hCD, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'hEF, 1'b0, 0, 1'b0, 1'b0);
`ifdef JPEG_BITBUFFER_UNSTUFF_EN
    check_eq("stuff_data",  {32'd0, out_data},    64'hFFABCDEF);
    check_eq("stuff_count", {57'd0, dut.count_q}, 64'd32);
`else
    check_eq("stuff_data",  {32'd0, out_data},    64'hFF00ABCD);
    check_eq("stuff_count", {57'd0, dut.count_q}, 64'd40);
`endif
    idle_flush();

    // Full buffer back-pressure
    for (int i = 0; i < 8; i++) cycle(1'b1, 8'h10 + 8'(i), 1'b0, 0, 1'b0, 1'b0);
    check_eq("full_count",  {57'd0, dut.count_q}, 64'd64);
    check_eq("full_accept", {63'd0, in_accept},   64'd0);
    cycle(1'b1, 8'hEE, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b0);
    check_eq("drain_accept", {63'd0, in_accept},   64'd1);
    check_eq("drain_count",  {57'd0, dut.count_q}, 64'd56);
    check_eq("drain_data",   {32'd0, out_data},    64'h11121314);
    idle_flush();

    // Last byte and clamped pop
    cycle(1'b1, 8'hA5, 1'b1, 0, 1'b0, 1'b0);
    check_eq("lastb_valid", {63'd0, out_valid}, 64'd1);
    check_eq("lastb_last",  {63'd0, out_last},  64'd1);
    check_eq("lastb_data",  {32'd0, out_data},  64'hA5000000);
    cycle(1'b0, 8'h00, 1'b0, 12, 1'b0, 1'b0);
    check_eq("clamp_count", {57'd0, dut.count_q}, 64'd0);
    check_eq("clamp_valid", {63'd0, out_valid},   64'd0);
    idle_flush();

    // Pop while invalid, then flush with a concurrent byte
    cycle(1'b1, 8'h01, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h02, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b1, 8'h03, 1'b0, 0, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 8, 1'b0, 1'b0);
    check_eq("nopop_count", {57'd0, dut.count_q}, 64'd24);
    cycle(1'b1, 8'h44, 1'b0, 8, 1'b1, 1'b0);
    check_eq("flush_count", {57'd0, dut.count_q}, 64'd0);
    check_eq("flush_valid", {63'd0, out_valid},   64'd0);
    check_eq("flush_last",  {63'd0, out_last},    64'd0);

    // Random traffic, 0xFF/0x00 biased to exercise stuffing
    for (int n = 0; n < 600; n++) begin
      logic [7:0] d;
      d = 8'($urandom);
      if ($urandom_range(0, 3) == 0) d = 8'hFF;
      else if ($urandom_range(0, 3) == 0) d = 8'h00;
      cycle($urandom_range(0, 3) != 0, d, $urandom_range(0, 49) == 0,
            int'($urandom_range(0, 32)), $urandom_range(0, 99) == 0,
            $urandom_range(0, 99) == 0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
